// File: rtl/reu_pkg.sv
// Shared encodings for the REU DMA transfer sequencer: transfer types,
// sequencer states and IncMode bit positions.
package reu_pkg;

  typedef enum logic [1:0] {
    XFER_STASH  = 2'b00,
    XFER_FETCH  = 2'b01,
    XFER_SWAP   = 2'b10,
    XFER_VERIFY = 2'b11
  } xferType_e;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_ARM,
    ST_ACQ,
    ST_C64RD,
    ST_REURD,
    ST_REUWR,
    ST_C64WR,
    ST_STEP,
    ST_DONE
  } seqState_e;

  localparam int INC_FIX_C64 = 1;
  localparam int INC_FIX_REU = 0;

  // Fetch is the only transfer that starts each byte on the REU side.
  function automatic seqState_e firstDataState(input xferType_e xfer);
    return (xfer == XFER_FETCH) ? ST_REURD : ST_C64RD;
  endfunction

endpackage

// File: rtl/reu_dma_settle.sv
// BA settle counter: Settled rises on the SETTLE_CYCLES-th consecutive BA=1
// cycle spent in ACQ. Only instantiated when REU_DMA_SETTLE_EN is defined.
module reu_dma_settle #(
  parameter int SETTLE_CYCLES = 3
) (
  input  logic PHI2,
  input  logic nReset,
  input  logic Acq,
  input  logic BA,
  output logic Settled
);

  localparam int CW = (SETTLE_CYCLES < 2) ? 1 : $clog2(SETTLE_CYCLES + 1);

  logic [CW-1:0] baRun;

  assign Settled = Acq && BA && (baRun == CW'(SETTLE_CYCLES - 1));

  always_ff @(negedge PHI2 or negedge nReset) begin
    if (!nReset) begin
      baRun <= '0;
    end else if (Acq && BA && !Settled) begin
      baRun <= baRun + 1'b1;
    end else begin
      baRun <= '0;
    end
  end

endmodule

// File: rtl/reu_xfer_seq.sv
// REU DMA transfer sequencer (stash/fetch/swap/verify) clocked on negedge PHI2.
// Optional BA settle delay in ACQ is enabled by defining REU_DMA_SETTLE_EN.
module reu_xfer_seq
  import reu_pkg::*;
`ifdef REU_DMA_SETTLE_EN
#(
  parameter int SETTLE_CYCLES = 3
)
`endif
(
  input  logic       PHI2,
  input  logic       nReset,
  input  logic       ExecuteEN,
  input  logic       FF00DecodeEN,
  input  logic       FF00Write,
  input  logic [1:0] XferType,
  input  logic [1:0] IncMode,
  input  logic       Length1,
  input  logic       BA,
  input  logic       RamAck,
  input  logic       DataMatch,
  output logic       nDMA,
  output logic       C64RdEn,
  output logic       C64WrEn,
  output logic       RamReq,
  output logic       RamWE,
  output logic       NextCA,
  output logic       NextREUA,
  output logic       NextLen,
  output logic       VerifyErr,
  output logic       Busy
);

  seqState_e state;
  seqState_e nextState;
  xferType_e xfer;
  logic      acqDone;

  assign xfer = xferType_e'(XferType);
  assign Busy = (state != ST_IDLE);

`ifdef REU_DMA_SETTLE_EN
  reu_dma_settle #(
    .SETTLE_CYCLES(SETTLE_CYCLES)
  ) uSettle (
    .PHI2    (PHI2),
    .nReset  (nReset),
    .Acq     (state == ST_ACQ),
    .BA      (BA),
    .Settled (acqDone)
  );
`else
  assign acqDone = BA;
`endif

  always_ff @(negedge PHI2 or negedge nReset) begin
    if (!nReset) begin
      state <= ST_IDLE;
    end else begin
      state <= nextState;
    end
  end

  always_comb begin
    nextState = state;
    nDMA      = 1'b1;
    C64RdEn   = 1'b0;
    C64WrEn   = 1'b0;
    RamReq    = 1'b0;
    RamWE     = 1'b0;
    NextCA    = 1'b0;
    NextREUA  = 1'b0;
    NextLen   = 1'b0;
    VerifyErr = 1'b0;

    unique case (state)
      ST_IDLE: begin
        if (ExecuteEN) nextState = ST_ARM;
      end
      ST_ARM: begin
        if (!FF00DecodeEN || FF00Write) nextState = ST_ACQ;
      end
      ST_ACQ: begin
        nDMA = 1'b0;
        if (acqDone) nextState = firstDataState(xfer);
      end
      // C64 bus cycles only happen while the VIC has released the bus.
      ST_C64RD: begin
        nDMA    = 1'b0;
        C64RdEn = BA;
        if (BA) nextState = (xfer == XFER_STASH) ? ST_REUWR : ST_REURD;
      end
      ST_C64WR: begin
        nDMA    = 1'b0;
        C64WrEn = BA;
        if (BA) nextState = ST_STEP;
      end
      // RamReq falls in the ack cycle so the controller never sees a second request.
      ST_REURD: begin
        nDMA   = 1'b0;
        RamReq = !RamAck;
        if (RamAck) begin
          unique case (xfer)
            XFER_FETCH: nextState = ST_C64WR;
            XFER_SWAP:  nextState = ST_REUWR;
            XFER_VERIFY: begin
              if (DataMatch) begin
                nextState = ST_STEP;
              end else begin
                VerifyErr = 1'b1;
                nextState = ST_DONE;
              end
            end
            default: nextState = ST_STEP;
          endcase
        end
      end
      ST_REUWR: begin
        nDMA   = 1'b0;
        RamReq = !RamAck;
        RamWE  = 1'b1;
        if (RamAck) nextState = (xfer == XFER_SWAP) ? ST_C64WR : ST_STEP;
      end
      ST_STEP: begin
        nDMA      = 1'b0;
        NextLen   = 1'b1;
        NextCA    = !IncMode[INC_FIX_C64];
        NextREUA  = !IncMode[INC_FIX_REU];
        nextState = Length1 ? ST_DONE : firstDataState(xfer);
      end
      ST_DONE: begin
        nextState = ST_IDLE;
      end
      default: begin
        nextState = ST_IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_reu_xfer_seq.sv
// Bench for reu_xfer_seq: drives register-file/bus/RAM behaviour and compares
// the observed bus/RAM/pulse event sequence with a transaction-level model.
module tb_reu_xfer_seq;

  logic       PHI2 = 1'b0;
  logic       nReset = 1'b0;
  logic       ExecuteEN = 1'b0;
  logic       FF00DecodeEN = 1'b0;
  logic       FF00Write = 1'b0;
  logic [1:0] XferType = 2'b00;
  logic [1:0] IncMode = 2'b00;
  logic       Length1 = 1'b0;
  logic       BA = 1'b1;
  logic       RamAck = 1'b0;
  logic       DataMatch = 1'b1;
  logic       nDMA, C64RdEn, C64WrEn, RamReq, RamWE;
  logic       NextCA, NextREUA, NextLen, VerifyErr, Busy;

  localparam int EV_RD    = 1;
  localparam int EV_RAMRD = 2;
  localparam int EV_RAMWR = 3;
  localparam int EV_WR    = 4;
  localparam int EV_PULSE = 16;
  localparam int EV_VERR  = 32;

  int nChecks = 0;
  int nErrors = 0;
  int expQ[$];
  int gotQ[$];

  reu_xfer_seq dut (
    .PHI2         (PHI2),
    .nReset       (nReset),
    .ExecuteEN    (ExecuteEN),
    .FF00DecodeEN (FF00DecodeEN),
    .FF00Write    (FF00Write),
    .XferType     (XferType),
    .IncMode      (IncMode),
    .Length1      (Length1),
    .BA           (BA),
    .RamAck       (RamAck),
    .DataMatch    (DataMatch),
    .nDMA         (nDMA),
    .C64RdEn      (C64RdEn),
    .C64WrEn      (C64WrEn),
    .RamReq       (RamReq),
    .RamWE        (RamWE),
    .NextCA       (NextCA),
    .NextREUA     (NextREUA),
    .NextLen      (NextLen),
    .VerifyErr    (VerifyErr),
    .Busy         (Busy)
  );

  always #5 PHI2 = ~PHI2;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nChecks++;
    if (got !== exp) begin
      nErrors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Expected event list for a whole transfer, straight from the transfer rules.
  task automatic buildModel(input int xfer, input logic [1:0] inc, input int len, input int mis);
    int stepEv;
    stepEv = EV_PULSE + 4 + (inc[1] ? 0 : 2) + (inc[0] ? 0 : 1);
    expQ.delete();
    for (int b = 0; b < len; b++) begin
      case (xfer)
        0: begin expQ.push_back(EV_RD); expQ.push_back(EV_RAMWR); end
        1: begin expQ.push_back(EV_RAMRD); expQ.push_back(EV_WR); end
        2: begin
          expQ.push_back(EV_RD); expQ.push_back(EV_RAMRD);
          expQ.push_back(EV_RAMWR); expQ.push_back(EV_WR);
        end
        default: begin expQ.push_back(EV_RD); expQ.push_back(EV_RAMRD); end
      endcase
      if (xfer == 3 && b == mis) begin
        expQ.push_back(EV_VERR);
        return;
      end
      expQ.push_back(stepEv);
    end
  endtask

  // baMode: 0 BA always 1, 1 random VIC stalls, 2 five-cycle stall after first RAM ack.
  task automatic runXfer(input string name, input int xfer, input logic [1:0] inc, input int len,
                         input int mis, input int baMode, input int ackFix, input bit ff00);
    int  rdCount, lenRem, reqAge, ackDelay, baHold, n;
    bit  started, done, prevReq, prevNdma, firstAck;
    buildModel(xfer, inc, len, mis);
    gotQ.delete();
    XferType     = 2'(xfer);
    IncMode      = inc;
    FF00DecodeEN = ff00;
    rdCount = 0; lenRem = len; reqAge = 0; baHold = 0;
    started = 0; done = 0; prevReq = 0; prevNdma = 1; firstAck = 1;
    ackDelay = (ackFix != 0) ? ackFix : int'($urandom_range(1, 3));
    for (int cyc = 0; cyc < 800 && !done; cyc++) begin
      @(posedge PHI2);
      ExecuteEN = !started;
      FF00Write = ff00 && (cyc == 6);
      Length1   = (lenRem == 1);
      RamAck    = (reqAge >= ackDelay);
      DataMatch = !(rdCount > 0 && (rdCount - 1) == mis);
      case (baMode)
        0: BA = 1'b1;
        1: BA = ($urandom_range(0, 4) != 0);
        default: BA = (baHold == 0);
      endcase
      if (baHold > 0) baHold--;
      #1;
      chk("strobeNeedsBA", (C64RdEn | C64WrEn) & ~BA, 0);
      chk("ownsBus", (C64RdEn | C64WrEn | RamReq | NextLen | VerifyErr) & nDMA, 0);
      chk("pulseExcl", NextLen & VerifyErr, 0);
      if (ff00 && cyc >= 1 && cyc <= 6) chk($sformatf("%s armHold%0d", name, cyc), nDMA, 1);
      if (ff00 && cyc == 7) chk($sformatf("%s ff00Acq", name), nDMA, 0);
      if (C64RdEn) gotQ.push_back(EV_RD);
      if (RamReq && !prevReq) gotQ.push_back(RamWE ? EV_RAMWR : EV_RAMRD);
      if (C64WrEn) gotQ.push_back(EV_WR);
      if (NextLen | NextCA | NextREUA)
        gotQ.push_back(EV_PULSE + 4 * int'(NextLen) + 2 * int'(NextCA) + int'(NextREUA));
      if (VerifyErr) gotQ.push_back(EV_VERR);
      rdCount += int'(C64RdEn);
      if (NextLen) lenRem--;
      if (RamAck) begin
        reqAge = 0;
        ackDelay = (ackFix != 0) ? ackFix : int'($urandom_range(1, 3));
        if (baMode == 2 && firstAck) baHold = 5;
        firstAck = 0;
      end else if (RamReq) begin
        reqAge++;
      end
      prevReq = RamReq;
      if (Busy) begin
        started = 1;
        prevNdma = nDMA;
      end else if (started) begin
        done = 1;
        chk($sformatf("%s doneNdma", name), prevNdma, 1);
        chk($sformatf("%s idleNdma", name), nDMA, 1);
      end
    end
    ExecuteEN = 1'b0;
    FF00Write = 1'b0;
    RamAck    = 1'b0;
    if (!done) chk($sformatf("%s timeout", name), 0, 1);
    chk($sformatf("%s evCount", name), gotQ.size(), expQ.size());
    n = (gotQ.size() < expQ.size()) ? gotQ.size() : expQ.size();
    for (int i = 0; i < n; i++) chk($sformatf("%s ev%0d", name, i), gotQ[i], expQ[i]);
  endtask

  initial begin
    bit found;
    repeat (2) @(posedge PHI2);
    #1;
    chk("rst nDMA", nDMA, 1);
    chk("rst Busy", Busy, 0);
    chk("rst RamReq", RamReq, 0);
    chk("rst strobes", {C64RdEn, C64WrEn, RamWE}, 0);
    chk("rst pulses", {NextCA, NextREUA, NextLen, VerifyErr}, 0);
    @(posedge PHI2);
    nReset = 1'b1;
    repeat (2) @(posedge PHI2);
    #1;
    chk("idle Busy", Busy, 0);

    runXfer("stash3", 0, 2'b00, 3, -1, 0, 2, 0);
    runXfer("swap1", 2, 2'b10, 1, -1, 0, 0, 0);
    runXfer("verifyMiss", 3, 2'b00, 4, 1, 0, 0, 0);
    runXfer("verifyLastMiss", 3, 2'b01, 2, 1, 1, 0, 0);
    runXfer("ff00Stash", 0, 2'b11, 2, -1, 0, 0, 1);
    runXfer("fetchStall", 1, 2'b00, 2, -1, 2, 0, 0);
    for (int t = 0; t < 12; t++) begin
      int x, l, m;
      x = int'($urandom_range(0, 3));
      l = int'($urandom_range(1, 5));
      m = (x == 3) ? int'($urandom_range(0, l)) : -1;
      runXfer($sformatf("rand%0d", t), x, 2'($urandom_range(0, 3)), l, m, 1, 0, ($urandom_range(0, 3) == 0));
    end

    // Asynchronous reset while a REU write is waiting for its ack.
    found = 0;
    XferType = 2'b00; IncMode = 2'b00; FF00DecodeEN = 1'b0; BA = 1'b1; Length1 = 1'b0;
    for (int cyc = 0; cyc < 50 && !found; cyc++) begin
      @(posedge PHI2);
      ExecuteEN = (cyc < 2);
      RamAck = 1'b0;
      #1;
      if (RamReq && RamWE) found = 1;
    end
    chk("rstReachREUWR", found, 1);
    #2 nReset = 1'b0;
    #1;
    chk("midRst nDMA", nDMA, 1);
    chk("midRst RamReq", RamReq, 0);
    chk("midRst Busy", Busy, 0);
    ExecuteEN = 1'b0;
    @(posedge PHI2);
    nReset = 1'b1;
    repeat (3) @(posedge PHI2);
    #1;
    chk("postRst Busy", Busy, 0);
    chk("postRst nDMA", nDMA, 1);

    $display("Simulation finished: %0d checks, %0d errors", nChecks, nErrors);
    $finish;
  end

endmodule
